// File: rtl/eth_mac_arp_dma_desc_sched.sv
// Single-channel DMA descriptor scheduler.
// Posted descriptors are queued in a small FIFO and then tagged. They are issued
// to the DMA engine under an outstanding-transfer credit limit. Returned status
// is matched against the oldest expected tag and turned into completion records
// and interrupt pulses.
module eth_mac_arp_dma_desc_sched #(
    parameter int DEPTH           = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable_i,
    input  logic                               flush_i,
    input  logic [ADDR_WIDTH-1:0]              s_desc_addr_i,
    input  logic [LEN_WIDTH-1:0]               s_desc_len_i,
    input  logic                               s_desc_valid_i,
    output logic                               s_desc_ready_o,
    output logic [ADDR_WIDTH-1:0]              m_dma_desc_addr_o,
    output logic [LEN_WIDTH-1:0]               m_dma_desc_len_o,
    output logic [TAG_WIDTH-1:0]               m_dma_desc_tag_o,
    output logic                               m_dma_desc_valid_o,
    input  logic                               m_dma_desc_ready_i,
    input  logic [LEN_WIDTH-1:0]               s_dma_status_len_i,
    input  logic [TAG_WIDTH-1:0]               s_dma_status_tag_i,
    input  logic [3:0]                         s_dma_status_error_i,
    input  logic                               s_dma_status_valid_i,
    output logic [LEN_WIDTH-1:0]               cpl_len_o,
    output logic [TAG_WIDTH-1:0]               cpl_tag_o,
    output logic [3:0]                         cpl_error_o,
    output logic                               cpl_valid_o,
    output logic [$clog2(DEPTH):0]             fifo_count_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               irq_done_o,
    output logic                               irq_error_o,
    output logic                               err_tag_mismatch_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                 state_q, state_d;

    logic [ADDR_WIDTH-1:0]  addrMem_q [DEPTH];
    logic [LEN_WIDTH-1:0]   lenMem_q  [DEPTH];
    logic [PTR_W-1:0]       wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]       count_q;

    logic [ADDR_WIDTH-1:0]  descAddr_q;
    logic [LEN_WIDTH-1:0]   descLen_q;
    logic [TAG_WIDTH-1:0]   descTag_q;
    logic                   descValid_q;
    logic [TAG_WIDTH-1:0]   issueTag_q;
    logic [TAG_WIDTH-1:0]   expTag_q;
    logic [OUT_W-1:0]       outCnt_q;

    logic [LEN_WIDTH-1:0]   cplLen_q;
    logic [TAG_WIDTH-1:0]   cplTag_q;
    logic [3:0]             cplErr_q;
    logic                   cplValid_q;
    logic                   irqDone_q;
    logic                   irqError_q;
    logic                   tagMismatch_q;

    logic                   push;
    logic                   loadIssue;
    logic                   handshake;
    logic                   statusAccepted;
    logic                   tagMatch;

    // Ready is the only combinational output: flush blocks a same-cycle push.
    assign s_desc_ready_o = (count_q < CNT_W'(DEPTH)) && !flush_i;
    assign push           = s_desc_valid_i && s_desc_ready_o;
    assign statusAccepted = s_dma_status_valid_i && (outCnt_q != '0);
    assign tagMatch       = (s_dma_status_tag_i == expTag_q);

    // Descriptor storage; contents need no reset because count/pointers gate use.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_q[wrPtr_q] <= s_desc_addr_i;
            lenMem_q[wrPtr_q]  <= s_desc_len_i;
        end
    end

    // FIFO pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (loadIssue) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(loadIssue);
        end
    end

    // Issue FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue FSM next state: load the head when credit allows, then wait for the handshake.
    always_comb begin
        state_d   = state_q;
        loadIssue = 1'b0;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i && (count_q != '0) && (outCnt_q < OUT_W'(MAX_OUTSTANDING))) begin
                    loadIssue = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (m_dma_desc_ready_i) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issue register: fields stay stable while valid is held; a tag is consumed on the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            descAddr_q  <= '0;
            descLen_q   <= '0;
            descTag_q   <= '0;
            descValid_q <= 1'b0;
            issueTag_q  <= '0;
        end else if (loadIssue) begin
            descAddr_q  <= addrMem_q[rdPtr_q];
            descLen_q   <= lenMem_q[rdPtr_q];
            descTag_q   <= issueTag_q;
            descValid_q <= 1'b1;
        end else if (handshake) begin
            descValid_q <= 1'b0;
            issueTag_q  <= issueTag_q + TAG_WIDTH'(1);
        end
    end

    // Outstanding credit: issues add, accepted statuses remove, simultaneous events cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outCnt_q <= '0;
        end else begin
            outCnt_q <= outCnt_q + OUT_W'(handshake) - OUT_W'(statusAccepted);
        end
    end

    // Completion records and interrupts; expected tag resyncs to the received tag + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cplLen_q      <= '0;
            cplTag_q      <= '0;
            cplErr_q      <= '0;
            cplValid_q    <= 1'b0;
            irqDone_q     <= 1'b0;
            irqError_q    <= 1'b0;
            tagMismatch_q <= 1'b0;
            expTag_q      <= '0;
        end else begin
            cplValid_q <= statusAccepted;
            irqDone_q  <= statusAccepted && (s_dma_status_error_i == 4'd0) && tagMatch;
            irqError_q <= s_dma_status_valid_i &&
                          ((outCnt_q == '0) || (s_dma_status_error_i != 4'd0) || !tagMatch);
            if (statusAccepted) begin
                cplLen_q <= s_dma_status_len_i;
                cplTag_q <= s_dma_status_tag_i;
                cplErr_q <= s_dma_status_error_i;
                expTag_q <= s_dma_status_tag_i + TAG_WIDTH'(1);
            end
            if (statusAccepted && !tagMatch) begin
                tagMismatch_q <= 1'b1;
            end else if (flush_i) begin
                tagMismatch_q <= 1'b0;
            end
        end
    end

    assign m_dma_desc_addr_o  = descAddr_q;
    assign m_dma_desc_len_o   = descLen_q;
    assign m_dma_desc_tag_o   = descTag_q;
    assign m_dma_desc_valid_o = descValid_q;
    assign cpl_len_o          = cplLen_q;
    assign cpl_tag_o          = cplTag_q;
    assign cpl_error_o        = cplErr_q;
    assign cpl_valid_o        = cplValid_q;
    assign fifo_count_o       = count_q;
    assign outstanding_o      = outCnt_q;
    assign irq_done_o         = irqDone_q;
    assign irq_error_o        = irqError_q;
    assign err_tag_mismatch_o = tagMismatch_q;

endmodule

// File: tb/tb_eth_mac_arp_dma_desc_sched.sv
// Bench for the DMA descriptor scheduler.
// A queue-based transaction model predicts every registered output each cycle.
module tb_eth_mac_arp_dma_desc_sched;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] sAddr = '0;
    logic [19:0] sLen = '0;
    logic        sValid = 1'b0;
    logic        sReady;
    logic [31:0] mAddr;
    logic [19:0] mLen;
    logic [7:0]  mTag;
    logic        mValid;
    logic        mReady = 1'b0;
    logic [19:0] stLen = '0;
    logic [7:0]  stTag = '0;
    logic [3:0]  stErr = '0;
    logic        stValid = 1'b0;
    logic [19:0] cplLen;
    logic [7:0]  cplTag;
    logic [3:0]  cplErr;
    logic        cplValid;
    logic [2:0]  fifoCount;
    logic [1:0]  outstanding;
    logic        irqDone;
    logic        irqError;
    logic        errMismatch;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [19:0] len;
    } desc_t;

    desc_t       fifoQ[$];
    desc_t       mPres;
    int          mPresTag;
    bit          mPresenting;
    int          mIssueTag;
    int          mExpTag;
    int          mOut;
    int          mIssues;
    bit          mCplValid;
    bit          mIrqDone;
    bit          mIrqErr;
    bit          mSticky;
    logic [19:0] mCplLen;
    logic [7:0]  mCplTag;
    logic [3:0]  mCplErr;

    eth_mac_arp_dma_desc_sched #(
        .DEPTH(DEPTH), .ADDR_WIDTH(32), .LEN_WIDTH(20), .TAG_WIDTH(8), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable_i(enable),
        .flush_i(flush),
        .s_desc_addr_i(sAddr),
        .s_desc_len_i(sLen),
        .s_desc_valid_i(sValid),
        .s_desc_ready_o(sReady),
        .m_dma_desc_addr_o(mAddr),
        .m_dma_desc_len_o(mLen),
        .m_dma_desc_tag_o(mTag),
        .m_dma_desc_valid_o(mValid),
        .m_dma_desc_ready_i(mReady),
        .s_dma_status_len_i(stLen),
        .s_dma_status_tag_i(stTag),
        .s_dma_status_error_i(stErr),
        .s_dma_status_valid_i(stValid),
        .cpl_len_o(cplLen),
        .cpl_tag_o(cplTag),
        .cpl_error_o(cplErr),
        .cpl_valid_o(cplValid),
        .fifo_count_o(fifoCount),
        .outstanding_o(outstanding),
        .irq_done_o(irqDone),
        .irq_error_o(irqError),
        .err_tag_mismatch_o(errMismatch)
    );

    always #5 clk = ~clk;

    task automatic expectEq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic modelReset();
        fifoQ.delete();
        mPres       = '{addr: '0, len: '0};
        mPresTag    = 0;
        mPresenting = 1'b0;
        mIssueTag   = 0;
        mExpTag     = 0;
        mOut        = 0;
        mCplValid   = 1'b0;
        mIrqDone    = 1'b0;
        mIrqErr     = 1'b0;
        mSticky     = 1'b0;
        mCplLen     = '0;
        mCplTag     = '0;
        mCplErr     = '0;
    endtask

    // One clock edge of the transaction model, using the inputs currently driven.
    task automatic modelStep();
        int  outOld;
        bit  accept;
        bit  hs;
        bit  issue;
        bit  mm;
        outOld = mOut;
        accept = sValid && (fifoQ.size() < DEPTH) && !flush;
        hs     = mPresenting && mReady;
        issue  = !mPresenting && enable && (fifoQ.size() > 0) && (mOut < MAXO);
        if (issue) begin
            mPres       = fifoQ.pop_front();
            mPresTag    = mIssueTag;
            mPresenting = 1'b1;
        end
        if (hs) begin
            mPresenting = 1'b0;
            mIssueTag   = (mIssueTag + 1) % 256;
            mOut++;
            mIssues++;
        end
        if (flush) fifoQ.delete();
        if (accept) fifoQ.push_back('{addr: sAddr, len: sLen});
        mCplValid = 1'b0;
        mIrqDone  = 1'b0;
        mIrqErr   = 1'b0;
        if (flush) mSticky = 1'b0;
        if (stValid) begin
            if (outOld > 0) begin
                mm        = (int'(stTag) != mExpTag);
                mOut--;
                mCplValid = 1'b1;
                mCplLen   = stLen;
                mCplTag   = stTag;
                mCplErr   = stErr;
                mExpTag   = (int'(stTag) + 1) % 256;
                mIrqDone  = !mm && (stErr == 4'd0);
                mIrqErr   = mm || (stErr != 4'd0);
                if (mm) mSticky = 1'b1;
            end else begin
                mIrqErr = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        expectEq("fifo_count", 64'(fifoCount), 64'(fifoQ.size()));
        expectEq("s_desc_ready", 64'(sReady), 64'((fifoQ.size() < DEPTH) && !flush));
        expectEq("desc_valid", 64'(mValid), 64'(mPresenting));
        expectEq("desc_addr", 64'(mAddr), 64'(mPres.addr));
        expectEq("desc_len", 64'(mLen), 64'(mPres.len));
        expectEq("desc_tag", 64'(mTag), 64'(mPresTag));
        expectEq("outstanding", 64'(outstanding), 64'(mOut));
        expectEq("cpl_valid", 64'(cplValid), 64'(mCplValid));
        expectEq("cpl_len", 64'(cplLen), 64'(mCplLen));
        expectEq("cpl_tag", 64'(cplTag), 64'(mCplTag));
        expectEq("cpl_error", 64'(cplErr), 64'(mCplErr));
        expectEq("irq_done", 64'(irqDone), 64'(mIrqDone));
        expectEq("irq_error", 64'(irqError), 64'(mIrqErr));
        expectEq("err_tag_mismatch", 64'(errMismatch), 64'(mSticky));
    endtask

    // Drive one cycle of inputs, advance the model and check after the edge.
    task automatic applyStimulus(input bit en, input bit fl, input bit sv, input logic [31:0] a,
                                 input logic [19:0] l, input bit mr, input bit stv,
                                 input logic [7:0] tg, input logic [19:0] sl, input logic [3:0] se);
        enable  = en;
        flush   = fl;
        sValid  = sv;
        sAddr   = a;
        sLen    = l;
        mReady  = mr;
        stValid = stv;
        stTag   = tg;
        stLen   = sl;
        stErr   = se;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n, input bit en, input bit mr);
        for (int i = 0; i < n; i++) applyStimulus(en, 0, 0, '0, '0, mr, 0, '0, '0, '0);
    endtask

    task automatic post(input logic [31:0] a, input logic [19:0] l, input bit en, input bit mr);
        applyStimulus(en, 0, 1, a, l, mr, 0, '0, '0, '0);
    endtask

    task automatic complete(input bit en, input bit mr, input logic [3:0] se);
        applyStimulus(en, 0, 0, '0, '0, mr, 1, 8'(mExpTag), 20'($urandom_range(1, 4096)), se);
    endtask

    task automatic resetDut();
        rst     = 1'b1;
        enable  = 1'b0;
        flush   = 1'b0;
        sValid  = 1'b0;
        mReady  = 1'b0;
        stValid = 1'b0;
        modelReset();
        #1;
        expectEq("valid_in_reset", 64'(mValid), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput();
    endtask

    initial begin
        modelReset();
        mIssues = 0;
        @(negedge clk);
        resetDut();

        $display("[TB] single descriptor issue and clean completion");
        post(32'h1000, 20'd64, 1, 1);
        idle(2, 1, 1);
        complete(1, 1, 4'd0);
        idle(1, 1, 1);

        $display("[TB] ready held low, credit limit");
        post(32'h2000, 20'd16, 1, 0);
        post(32'h3000, 20'd32, 1, 0);
        post(32'h4000, 20'd48, 1, 0);
        idle(10, 1, 0);
        idle(6, 1, 1);
        complete(1, 1, 4'd0);
        idle(3, 1, 1);
        complete(1, 1, 4'd0);
        complete(1, 1, 4'd0);
        idle(1, 1, 1);

        $display("[TB] full FIFO with issue disabled, then flush");
        for (int i = 0; i < 5; i++) post(32'h5000 + 32'(i * 16), 20'(i + 1), 0, 1);
        idle(2, 0, 1);
        applyStimulus(0, 1, 1, 32'h9999, 20'd9, 1, 0, '0, '0, '0);
        idle(3, 0, 1);

        $display("[TB] randomized traffic across tag wrap");
        for (int i = 0; i < 1400; i++) begin
            bit stv;
            stv = (mOut > 0) && ($urandom_range(0, 1) == 1);
            applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0,
                          $urandom_range(0, 3) != 0, $urandom, 20'($urandom),
                          $urandom_range(0, 3) != 0, stv, 8'(mExpTag),
                          20'($urandom),
                          ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
        end
        for (int i = 0; i < 4; i++) begin
            if (mOut > 0) complete(0, 1, 4'd0);
            else idle(1, 0, 1);
        end
        $display("[TB] descriptors issued so far: %0d", mIssues);

        $display("[TB] tag mismatch and unexpected status");
        resetDut();
        post(32'hA000, 20'd100, 1, 1);
        idle(2, 1, 1);
        applyStimulus(1, 0, 0, '0, '0, 1, 1, 8'd5, 20'd100, 4'd0);
        idle(1, 1, 1);
        applyStimulus(1, 0, 0, '0, '0, 1, 1, 8'd7, 20'd8, 4'd0);
        idle(1, 1, 1);
        applyStimulus(1, 1, 0, '0, '0, 1, 0, '0, '0, '0);
        idle(1, 1, 1);

        $display("[TB] reset during ISSUE");
        post(32'hB000, 20'd200, 1, 0);
        post(32'hC000, 20'd300, 1, 0);
        idle(2, 1, 0);
        resetDut();
        post(32'hD000, 20'd400, 1, 1);
        idle(3, 1, 1);
        complete(1, 1, 4'd0);
        idle(2, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
